// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block and its divider.
package pwm_pkg;
  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int DUTY_W    = 7;
  localparam int PCT_SCALE = 100;
endpackage

// File: rtl/pwm_div.sv
// Iterative restoring divider: one quotient bit per cycle, NUM_W cycles per division.
// Only the low DUTY_W quotient bits are exported; the caller guarantees the result fits.
module pwm_div
  import pwm_pkg::*;
#(
  parameter int NUM_W = 23,
  parameter int DEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_W-1:0]  num,
  input  logic [DEN_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quot
);
  localparam int STEP_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0]  q;
  logic [DEN_W-1:0]  rem;
  logic [DEN_W-1:0]  dvs;
  logic [STEP_W-1:0] steps;
  logic [DEN_W:0]    rem_sh;
  logic [DEN_W:0]    diff;
  logic              fits;

  // rem < dvs always holds, so the sign of the trial difference is the borrow
  always_comb begin
    rem_sh = {rem, q[NUM_W-1]};
    diff   = rem_sh - {1'b0, dvs};
    fits   = ~diff[DEN_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      rem   <= '0;
      dvs   <= '0;
      steps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (start && !busy) begin
        q     <= num;
        rem   <= '0;
        dvs   <= den;
        steps <= STEP_W'(NUM_W);
        busy  <= 1'b1;
      end else if (busy) begin
        q     <= {q[NUM_W-2:0], fits};
        rem   <= fits ? diff[DEN_W-1:0] : rem_sh[DEN_W-1:0];
        steps <= steps - 1'b1;
        if (steps == STEP_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quot = q[DUTY_W-1:0];
endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: high time, period and duty percentage per completed period, plus stuck-line detect.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to insert a 3-tap majority filter after the synchronizer.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic              meas_valid,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              duty_valid,
  output logic              stuck,
  output logic              overrun
);
  localparam int NUM_W = CNT_W + DUTY_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic rst_p0, rst_p1, rst_int_n;
  logic sync_p0, sync_p1, lvl, lvl_dly;
  logic rise, fall, edge_any, timeout_hit;
  state_t state;
  logic [CNT_W-1:0]  hcnt, pcnt, idle;
  logic              div_start, div_busy, div_done;
  logic [NUM_W-1:0]  div_num;
  logic [DUTY_W-1:0] div_quot;

  // Reset: asynchronous assert, release aligned to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rst_p1, rst_p0} <= 2'b00;
    else        {rst_p1, rst_p0} <= {rst_p0, 1'b1};
  end
  assign rst_int_n = rst_p1;

  // Stages p0/p1: metastability synchronizer
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pwm_in;
      sync_p1 <= sync_p0;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic tap_p2, tap_p3, filt_p4;

  // Stages p2..p4: majority vote over three samples drops 1-cycle glitches
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      tap_p2  <= 1'b0;
      tap_p3  <= 1'b0;
      filt_p4 <= 1'b0;
    end else begin
      tap_p2  <= sync_p1;
      tap_p3  <= tap_p2;
      filt_p4 <= maj3(sync_p1, tap_p2, tap_p3);
    end
  end
  assign lvl = filt_p4;
`else
  assign lvl = sync_p1;
`endif

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) lvl_dly <= 1'b0;
    else            lvl_dly <= lvl;
  end

  assign rise        = lvl & ~lvl_dly;
  assign fall        = ~lvl & lvl_dly;
  assign edge_any    = rise | fall;
  assign timeout_hit = !edge_any && (idle == CNT_W'(TIMEOUT - 1));
  assign div_start   = (state == LOW) && rise;
  assign div_num     = NUM_W'(hcnt) * NUM_W'(PCT_SCALE);

  pwm_div #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_int_n),
    .start (div_start),
    .abort (timeout_hit),
    .num   (div_num),
    .den   (pcnt),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= SEEK;
      hcnt       <= '0;
      pcnt       <= '0;
      idle       <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      duty_pct   <= '0;
      duty_valid <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      duty_valid <= 1'b0;
      overrun    <= 1'b0;

      if (edge_any) begin
        idle  <= '0;
        stuck <= 1'b0;
      end else if (idle != CNT_W'(TIMEOUT)) begin
        idle <= idle + 1'b1;
      end

      if (div_done) begin
        duty_pct   <= div_quot;
        duty_valid <= 1'b1;
      end

      case (state)
        SEEK: begin
          if (rise) begin
            hcnt  <= CNT_W'(1);
            pcnt  <= CNT_W'(1);
            state <= HIGH;
          end
        end
        HIGH: begin
          pcnt <= sat_inc(pcnt);
          if (fall) state <= LOW;
          else      hcnt  <= sat_inc(hcnt);
        end
        LOW: begin
          if (rise) begin
            // A period that closes while the divider is still working is dropped whole
            if (div_busy) begin
              overrun <= 1'b1;
            end else begin
              high_cnt   <= hcnt;
              period_cnt <= pcnt;
              meas_valid <= 1'b1;
            end
            hcnt  <= CNT_W'(1);
            pcnt  <= CNT_W'(1);
            state <= HIGH;
          end else begin
            pcnt <= sat_inc(pcnt);
          end
        end
        default: state <= SEEK;
      endcase

      // A stuck line overrides any divider result landing in the same cycle
      if (timeout_hit) begin
        stuck      <= 1'b1;
        duty_pct   <= lvl ? DUTY_W'(PCT_SCALE) : '0;
        duty_valid <= 1'b1;
        high_cnt   <= '0;
        period_cnt <= '0;
        state      <= SEEK;
      end
    end
  end
endmodule
